// File: rtl/inst_queue.sv
`default_nettype none
// ============================================================================
//  Module   : inst_queue
//  Purpose  : Dual-issue instruction queue between fetch and the two decode
//             slots. Circular buffer of DEPTH {instr, pc} entries; presents
//             the two oldest entries in program order, accepts 0/1/2 pushes
//             and 0/1/2 pops per cycle, and is emptied by a redirect flush.
//  Options  : IQ_BYPASS_EN - when the queue is empty, fetch inputs are
//             forwarded combinationally to the decode outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module inst_queue #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic [1:0]    in_valid,
   input  logic [31:0]   in_instr0,
   input  logic [31:0]   in_instr1,
   input  logic [31:0]   in_pc0,
   input  logic [31:0]   in_pc1,
   output logic          in_ready,
   output logic [1:0]    out_valid,
   output logic [31:0]   out_instr0,
   output logic [31:0]   out_instr1,
   output logic [31:0]   out_pc0,
   output logic [31:0]   out_pc1,
   input  logic [1:0]    pop_cnt,
   output logic [AW:0]   count
);

   // Highest occupancy at which a full 2-wide push still fits.
   localparam logic [AW:0] READY_MAX = (AW+1)'(DEPTH - 2);

   logic [31:0]   instr_mem_q [DEPTH];
   logic [31:0]   instr_mem_d [DEPTH];
   logic [31:0]   pc_mem_q    [DEPTH];
   logic [31:0]   pc_mem_d    [DEPTH];

   logic [AW-1:0] head_q, head_d;
   logic [AW-1:0] tail_q, tail_d;
   logic [AW:0]   count_q, count_d;

   logic [AW-1:0] head_p1;
   logic [AW-1:0] tail_p1;
   logic          bypass;
   logic          push_ok;
   logic [1:0]    n_avail;
   logic [1:0]    pop_req;
   logic [1:0]    n_pop;
   logic [1:0]    n_push;
   logic [1:0]    skip;

   // Decode-side view: either the two oldest stored entries or, when the
   // queue is empty and bypass is built in, the incoming fetch pair.
   always_comb begin
      head_p1    = head_q + AW'(1);
`ifdef IQ_BYPASS_EN
      bypass     = (count_q == '0) && !flush;
`else
      bypass     = 1'b0;
`endif
      in_ready   = (count_q <= READY_MAX);
      count      = count_q;
      out_valid  = 2'b00;
      out_instr0 = 32'h0;
      out_instr1 = 32'h0;
      out_pc0    = 32'h0;
      out_pc1    = 32'h0;
      if (bypass) begin
         // in_valid=10 is not a legal pair and is shown as nothing.
         case (in_valid)
            2'b01:   out_valid = 2'b01;
            2'b11:   out_valid = 2'b11;
            default: out_valid = 2'b00;
         endcase
         if (out_valid[0]) begin
            out_instr0 = in_instr0;
            out_pc0    = in_pc0;
         end
         if (out_valid[1]) begin
            out_instr1 = in_instr1;
            out_pc1    = in_pc1;
         end
      end else begin
         out_valid[0] = (count_q != '0);
         out_valid[1] = (count_q >= (AW+1)'(2));
         if (out_valid[0]) begin
            out_instr0 = instr_mem_q[head_q];
            out_pc0    = pc_mem_q[head_q];
         end
         if (out_valid[1]) begin
            out_instr1 = instr_mem_q[head_p1];
            out_pc1    = pc_mem_q[head_p1];
         end
      end
   end

   // Next-state: clamp the pop to what is presented, accept the push only
   // on the current occupancy, and skip storing bypassed entries that the
   // decoders consume in the same cycle.
   always_comb begin
      tail_p1     = tail_q + AW'(1);
      n_avail     = {1'b0, out_valid[1]} + {1'b0, out_valid[0]};
      pop_req     = (pop_cnt == 2'd3) ? 2'd2 : pop_cnt;
      n_pop       = (pop_req < n_avail) ? pop_req : n_avail;
      push_ok     = in_ready && !flush;
      n_push      = 2'd0;
      if (push_ok) begin
         if (in_valid == 2'b11)
            n_push = 2'd2;
         else if (in_valid == 2'b01)
            n_push = 2'd1;
      end
      skip        = bypass ? n_pop : 2'd0;

      instr_mem_d = instr_mem_q;
      pc_mem_d    = pc_mem_q;
      // Entry k lands at tail+k; with bypass the head moves past the skipped
      // slots by the same amount, so pointers stay consistent.
      if (n_push != 2'd0 && skip == 2'd0) begin
         instr_mem_d[tail_q] = in_instr0;
         pc_mem_d[tail_q]    = in_pc0;
      end
      if (n_push == 2'd2 && skip != 2'd2) begin
         instr_mem_d[tail_p1] = in_instr1;
         pc_mem_d[tail_p1]    = in_pc1;
      end

      head_d  = head_q + AW'(n_pop);
      tail_d  = tail_q + AW'(n_push);
      count_d = count_q + (AW+1)'(n_push) - (AW+1)'(n_pop);
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage; contents are never cleared, only pointers are.
   always_ff @(posedge clk) begin
      instr_mem_q <= instr_mem_d;
      pc_mem_q    <= pc_mem_d;
   end

endmodule
`default_nettype wire

// File: tb/tb_inst_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_queue
//  Purpose  : Self-checking bench for inst_queue: queue-based reference model
//             compared every cycle, plus directed literal expectations.
//             Honours IQ_BYPASS_EN when the same macro is defined for the bench.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_inst_queue;

   localparam int DEPTH = 8;
   localparam int AW    = 3;
`ifdef IQ_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          clk;
   logic          rst_n;
   logic          flush;
   logic [1:0]    in_valid;
   logic [31:0]   in_instr0, in_instr1, in_pc0, in_pc1;
   logic          in_ready;
   logic [1:0]    out_valid;
   logic [31:0]   out_instr0, out_instr1, out_pc0, out_pc1;
   logic [1:0]    pop_cnt;
   logic [AW:0]   count;

   inst_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_instr0  (in_instr0),
      .in_instr1  (in_instr1),
      .in_pc0     (in_pc0),
      .in_pc1     (in_pc1),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_instr0 (out_instr0),
      .out_instr1 (out_instr1),
      .out_pc0    (out_pc0),
      .out_pc1    (out_pc1),
      .pop_cnt    (pop_cnt),
      .count      (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } ent_t;

   ent_t mq[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Entries the decoders should see this cycle, by the queue rules.
   function automatic int presented(output ent_t e0, output ent_t e1, output bit byp);
      int n;
      e0  = '0;
      e1  = '0;
      byp = BYP && (mq.size() == 0) && !flush;
      if (byp) begin
         n = (in_valid == 2'b11) ? 2 : (in_valid == 2'b01) ? 1 : 0;
         if (n >= 1) e0 = '{in_instr0, in_pc0};
         if (n >= 2) e1 = '{in_instr1, in_pc1};
      end else begin
         n = (mq.size() >= 2) ? 2 : mq.size();
         if (n >= 1) e0 = mq[0];
         if (n >= 2) e1 = mq[1];
      end
      return n;
   endfunction

   // Reference model state update on each edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
      end else begin
         ent_t e0, e1;
         bit   byp;
         int   n, req, eff;
         ent_t inc[$];
         n   = presented(e0, e1, byp);
         req = (pop_cnt == 2'd3) ? 2 : int'(pop_cnt);
         eff = (req < n) ? req : n;
         if (flush) begin
            mq.delete();
         end else if (byp) begin
            if (n >= 1) inc.push_back(e0);
            if (n >= 2) inc.push_back(e1);
            for (int k = eff; k < n; k++) mq.push_back(inc[k]);
         end else begin
            bit ready;
            ready = (mq.size() <= DEPTH - 2);
            for (int k = 0; k < eff; k++) void'(mq.pop_front());
            if (ready && in_valid == 2'b01) begin
               mq.push_back('{in_instr0, in_pc0});
            end else if (ready && in_valid == 2'b11) begin
               mq.push_back('{in_instr0, in_pc0});
               mq.push_back('{in_instr1, in_pc1});
            end
         end
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (rst_n) begin
         ent_t e0, e1;
         bit   byp;
         int   n;
         n = presented(e0, e1, byp);
         chk("cyc_out_valid", 64'(out_valid), (n == 2) ? 64'h3 : (n == 1) ? 64'h1 : 64'h0);
         chk("cyc_out_instr0", 64'(out_instr0), 64'(e0.instr));
         chk("cyc_out_pc0", 64'(out_pc0), 64'(e0.pc));
         chk("cyc_out_instr1", 64'(out_instr1), 64'(e1.instr));
         chk("cyc_out_pc1", 64'(out_pc1), 64'(e1.pc));
         chk("cyc_in_ready", 64'(in_ready), 64'(mq.size() <= DEPTH - 2));
         chk("cyc_count", 64'(count), 64'(mq.size()));
      end
   end

   task automatic idle_inputs();
      flush     = 1'b0;
      in_valid  = 2'b00;
      in_instr0 = 32'h0;
      in_instr1 = 32'h0;
      in_pc0    = 32'h0;
      in_pc1    = 32'h0;
      pop_cnt   = 2'd0;
   endtask

   // One clock cycle of stimulus; returns 1 time unit after the edge with idle inputs.
   task automatic cyc(input logic f, input logic [1:0] v,
                      input logic [31:0] i0, input logic [31:0] p0,
                      input logic [31:0] i1, input logic [31:0] p1,
                      input logic [1:0] pc);
      flush     = f;
      in_valid  = v;
      in_instr0 = i0;
      in_pc0    = p0;
      in_instr1 = i1;
      in_pc1    = p1;
      pop_cnt   = pc;
      @(posedge clk);
      #1;
      idle_inputs();
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      // Reset / idle state
      chk("rst_out_valid", 64'(out_valid), 64'h0);
      chk("rst_out_instr0", 64'(out_instr0), 64'h0);
      chk("rst_in_ready", 64'(in_ready), 64'h1);
      chk("rst_count", 64'(count), 64'h0);

      // Two pairs, no pop
      cyc(1'b0, 2'b11, 32'h20080001, 32'h0, 32'h20090002, 32'h4, 2'd0);
      cyc(1'b0, 2'b11, 32'h01095020, 32'h8, 32'h08000000, 32'hC, 2'd0);
      chk("fill4_count", 64'(count), 64'd4);
      chk("fill4_instr0", 64'(out_instr0), 64'h20080001);
      chk("fill4_instr1", 64'(out_instr1), 64'h20090002);
      chk("fill4_pc1", 64'(out_pc1), 64'h4);

      // Pop 1 then 2
      cyc(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'd1);
      chk("pop1_pc0", 64'(out_pc0), 64'h4);
      chk("pop1_count", 64'(count), 64'd3);
      cyc(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'd2);
      chk("pop2_pc0", 64'(out_pc0), 64'hC);
      chk("pop2_count", 64'(count), 64'd1);
      chk("pop2_valid", 64'(out_valid), 64'h1);

      // Fill to 7
      for (int i = 0; i < 3; i++) begin
         logic [31:0] pa;
         pa = 32'h10 + 32'(8 * i);
         cyc(1'b0, 2'b11, 32'h10000000 + pa, pa, 32'h10000004 + pa, pa + 32'h4, 2'd0);
      end
      chk("full_count", 64'(count), 64'd7);
      chk("full_in_ready", 64'(in_ready), 64'h0);
      cyc(1'b0, 2'b11, 32'hDEAD0100, 32'h100, 32'hDEAD0104, 32'h104, 2'd0);
      chk("drop_count", 64'(count), 64'd7);
      cyc(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'd2);
      chk("drain_count", 64'(count), 64'd5);
      chk("drain_in_ready", 64'(in_ready), 64'h1);

      // Steady 2-in/2-out across the pointer wrap (one cycle uses pop_cnt=3)
      for (int i = 0; i < 6; i++) begin
         logic [31:0] pa;
         pa = 32'h200 + 32'(8 * i);
         cyc(1'b0, 2'b11, 32'h20000000 + pa, pa, 32'h20000004 + pa, pa + 32'h4,
             (i == 2) ? 2'd3 : 2'd2);
      end
      chk("wrap_count", 64'(count), 64'd5);
      chk("wrap_pc0", 64'(out_pc0), 64'h21C);
      chk("wrap_instr1", 64'(out_instr1), 64'h20000220);

      // Flush overrides push and pop
      cyc(1'b0, 2'b01, 32'h30000300, 32'h300, 32'h0, 32'h0, 2'd0);
      chk("pre_flush_count", 64'(count), 64'd6);
      cyc(1'b1, 2'b11, 32'hBAD00000, 32'h500, 32'hBAD00004, 32'h504, 2'd2);
      chk("flush_count", 64'(count), 64'd0);
      chk("flush_valid", 64'(out_valid), 64'h0);
      cyc(1'b0, 2'b01, 32'h0C000010, 32'h40, 32'h0, 32'h0, 2'd0);
      chk("post_flush_pc0", 64'(out_pc0), 64'h40);
      chk("post_flush_instr0", 64'(out_instr0), 64'h0C000010);

      // Over-pop clamps, illegal 10 pattern writes nothing
      cyc(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'd2);
      chk("overpop_count", 64'(count), 64'd0);
      cyc(1'b0, 2'b10, 32'h11111111, 32'h60, 32'h22222222, 32'h64, 2'd0);
      chk("illegal10_count", 64'(count), 64'd0);
      chk("illegal10_valid", 64'(out_valid), 64'h0);

      // Empty-queue push with same-cycle pop
      flush     = 1'b0;
      in_valid  = 2'b01;
      in_instr0 = 32'h8D090000;
      in_pc0    = 32'h80;
      pop_cnt   = 2'd1;
      #1;
`ifdef IQ_BYPASS_EN
      chk("byp_same_valid", 64'(out_valid), 64'h1);
      chk("byp_same_instr0", 64'(out_instr0), 64'h8D090000);
`else
      chk("nobyp_same_valid", 64'(out_valid), 64'h0);
      chk("nobyp_same_instr0", 64'(out_instr0), 64'h0);
`endif
      @(posedge clk);
      #1;
      idle_inputs();
`ifdef IQ_BYPASS_EN
      chk("byp_next_count", 64'(count), 64'd0);
`else
      chk("nobyp_next_count", 64'(count), 64'd1);
      chk("nobyp_next_instr0", 64'(out_instr0), 64'h8D090000);
      chk("nobyp_next_pc0", 64'(out_pc0), 64'h80);
`endif
      cyc(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'd1);

      // Asynchronous reset with count=5, in the middle of a push
      cyc(1'b0, 2'b11, 32'h40000400, 32'h400, 32'h40000404, 32'h404, 2'd0);
      cyc(1'b0, 2'b11, 32'h40000408, 32'h408, 32'h4000040C, 32'h40C, 2'd0);
      cyc(1'b0, 2'b01, 32'h40000410, 32'h410, 32'h0, 32'h0, 2'd0);
      chk("pre_rst_count", 64'(count), 64'd5);
      in_valid  = 2'b11;
      in_instr0 = 32'h50000000;
      in_pc0    = 32'h500;
      in_instr1 = 32'h50000004;
      in_pc1    = 32'h504;
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_count", 64'(count), 64'd0);
      chk("async_rst_in_ready", 64'(in_ready), 64'h1);
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("after_rst_count", 64'(count), 64'd0);
      chk("after_rst_valid", 64'(out_valid), 64'h0);

      repeat (2) @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/inst_queue.md
# inst_queue

Dual-issue instruction queue between the fetch stage and the two decode slots. It buffers up to DEPTH fetched instructions with their PCs. Each cycle it presents the two oldest entries, in program order, to the slot-0 and slot-1 control decoders. Issue logic pops 0, 1 or 2 entries per cycle. A redirect from a taken branch, J/JAL or JR (PCsrc path) flushes the whole queue.

## Interface
- DEPTH, 8: entry count; power of two, ≥4
- AW, 3: pointer width, log2(DEPTH)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  discard all entries; overrides push and pop this cycle
- in_valid  input  2  fetch slot valids; bit0 = older instruction
- in_instr0 / in_instr1  input  32  fetched instructions
- in_pc0 / in_pc1  input  32  PCs of the fetched instructions
- in_ready  output  1  queue can accept a 2-wide push this cycle
- out_valid  output  2  bit0 = head entry valid, bit1 = head+1 valid
- out_instr0 / out_instr1  output  32  head / head+1 instruction; 32'h0 when not valid
- out_pc0 / out_pc1  output  32  head / head+1 PC; 32'h0 when not valid
- pop_cnt  input  2  entries consumed by issue this cycle (0, 1, 2)
- count  output  AW+1  current occupancy

## Operation
- Storage is a circular buffer with head pointer, tail pointer (AW bits, natural wrap) and an AW+1-bit count.
- in_ready = (count ≤ DEPTH−2). It is computed from the current count only; a same-cycle pop grants no credit.
- Push, when in_ready=1 and flush=0:
  - in_valid=01 writes instr0/pc0 at tail; tail += 1.
  - in_valid=11 writes instr0 at tail and instr1 at tail+1; tail += 2.
  - in_valid=10 is illegal and writes nothing.
  - in_valid≠00 while in_ready=0 is dropped; fetch must hold the pair.
- Pop: the effective pop is min(pop_cnt, popcount(out_valid)). pop_cnt=3 is treated as 2. head += effective pop.
- count_next = count + pushed − popped. Simultaneous push and pop are both applied.
- out_valid[0] = (count ≥ 1); out_valid[1] = (count ≥ 2). Outputs come from head and head+1 modulo DEPTH. Invalid slots are driven 32'h0.
- flush=1: head, tail and count go to 0 on the next edge; in_valid and pop_cnt are ignored that cycle. Storage contents are not cleared.
- Reset, asynchronous on rst_n low: head=tail=count=0. Reset values: out_valid=00, out_instr/out_pc=0, in_ready=1, count=0. Reset mid-push discards the pair.

## Timing
- Without bypass, a push at edge N is visible on out_* after edge N; minimum fetch-to-decode latency is 1 cycle.
- out_*, in_ready and count are combinational from registered state only. No input-to-output path exists except under IQ_BYPASS_EN.
- The flush edge clears the queue. The first post-flush push can be accepted in the same cycle as flush deassertion.
- Full throughput: 2 pushes plus 2 pops per cycle is sustained at any count between 2 and DEPTH−2.

## Configuration
- IQ_BYPASS_EN defined: when count=0 and flush=0, out_* are driven combinationally from in_instr/in_pc/in_valid (in_valid=10 is presented as 00).
  - Bypassed entries popped in the same cycle are not written.
  - Un-popped bypassed entries are written normally, and count reflects them.
  - Fetch-to-decode latency becomes 0 cycles when the queue is empty.
- IQ_BYPASS_EN undefined: no bypass; an empty queue always presents out_valid=00.

## Test plan
- Reset then idle: out_valid=00, out_instr0=0, in_ready=1, count=0. Assert rst_n low mid-run with count=5, and count=0 immediately.
- Push pairs {0x20080001@0x0, 0x20090002@0x4}, then {0x01095020@0x8, 0x08000000@0xC}, with pop_cnt=0: count=4; out_instr0=0x20080001, out_instr1=0x20090002, out_pc1=0x4.
- From count=4, pop_cnt=1 for one cycle, then pop_cnt=2: head advances to PC 0x4, then 0xC; count goes 3 then 1; out_valid=01.
- Fill to count=7: in_ready=0; a push with in_valid=11 is dropped and count stays 7. pop_cnt=2 with no push gives count=5 and in_ready=1. Run 2-in/2-out across the pointer wrap: PCs exit in order.
- count=6 with flush=1, in_valid=11, pop_cnt=2: next cycle count=0 and out_valid=00. Next cycle push 0x0C000010@0x40: it appears at out_pc0=0x40.
- With IQ_BYPASS_EN, empty queue, push 0x8D090000@0x80 with pop_cnt=1 in the same cycle: out_instr0=0x8D090000 in that cycle and count stays 0. Without the macro, out_valid=00 in that cycle and the instruction appears next cycle.
